// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with centre sampling, runtime parity/stop modes
// and a show-ahead frame FIFO popped through a valid/ready handshake.
`timescale 1ns/1ps
module uart_rx_ovs #(
    parameter int DATA_BITS  = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          tick,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_done,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(OVS);
    localparam int BW = 4;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam int EW = DATA_BITS + 2;

    localparam logic [CW-1:0] HALF_END = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(OVS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    state_e                state_q, state_d;
    logic                  s1_q, s1_d;
    logic                  rs_q, rs_d;
    logic                  rs_prev_q, rs_prev_d;
    logic                  armed_q, armed_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  ferr_q, ferr_d;
    logic                  stop_sec_q, stop_sec_d;
    logic                  pen_q, pen_d;
    logic                  odd_q, odd_d;
    logic                  two_q, two_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [NW-1:0]         count_q, count_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [EW-1:0]         mem_d [FIFO_DEPTH];

    logic                  tk;
    logic                  push;
    logic                  push_ferr;
    logic [EW-1:0]         push_word;
    logic                  pop;
    logic                  full;
    logic                  wr;
    logic [EW-1:0]         head;

    // A tick landing on the reset-release edge must not advance anything
    assign tk = tick & armed_q;

    always_comb begin
        s1_d       = rx;
        rs_d       = s1_q;
        rs_prev_d  = rs_q;
        armed_d    = 1'b1;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        stop_sec_d = stop_sec_q;
        pen_d      = pen_q;
        odd_d      = odd_q;
        two_d      = two_q;
        push       = 1'b0;
        push_ferr  = ferr_q;
        unique case (state_q)
            S_IDLE: begin
                if (rs_prev_q && !rs_q) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    bit_d      = '0;
                    shift_d    = '0;
                    par_d      = 1'b0;
                    ferr_d     = 1'b0;
                    stop_sec_d = 1'b0;
                    pen_d      = parity_en;
                    odd_d      = parity_odd;
                    two_d      = stop2;
                end
            end
            S_START: begin
                if (tk) begin
                    if (cnt_q == HALF_END) begin
                        cnt_d   = '0;
                        state_d = rs_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (tk) begin
                    if (cnt_q == BIT_END) begin
                        cnt_d   = '0;
                        shift_d = {rs_q, shift_q[DATA_BITS-1:1]};
                        par_d   = par_q ^ rs_q;
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = pen_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tk) begin
                    if (cnt_q == BIT_END) begin
                        cnt_d   = '0;
                        par_d   = par_q ^ rs_q ^ odd_q;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tk) begin
                    if (cnt_q == BIT_END) begin
                        cnt_d = '0;
                        if (two_q && !stop_sec_q) begin
                            stop_sec_d = 1'b1;
                            ferr_d     = ferr_q | ~rs_q;
                        end else begin
                            push      = 1'b1;
                            push_ferr = ferr_q | ~rs_q;
                            ferr_d    = push_ferr;
                            state_d   = rs_q ? S_IDLE : S_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign push_word = {shift_q, pen_q & par_q, push_ferr};

    always_comb begin
        pop     = (count_q != '0) && rx_ready;
        full    = (count_q == DEPTH_N);
        wr      = push && (!full || pop);
        done_d  = push;
        ovr_d   = push && full && !pop;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr) begin
            mem_d[wptr_q] = push_word;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        unique case (1'b1)
            (wr && !pop): count_d = count_q + NW'(1);
            (pop && !wr): count_d = count_q - NW'(1);
            default:      count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            s1_q       <= 1'b1;
            rs_q       <= 1'b1;
            rs_prev_q  <= 1'b1;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            stop_sec_q <= 1'b0;
            pen_q      <= 1'b0;
            odd_q      <= 1'b0;
            two_q      <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            rs_q       <= rs_d;
            rs_prev_q  <= rs_prev_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            ferr_q     <= ferr_d;
            stop_sec_q <= stop_sec_d;
            pen_q      <= pen_d;
            odd_q      <= odd_d;
            two_q      <= two_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign head       = mem_q[rptr_q];
    assign rx_data    = head[EW-1:2];
    assign rx_perr    = head[1];
    assign rx_ferr    = head[0];
    assign rx_valid   = (count_q != '0);
    assign rx_done    = done_q;
    assign overrun    = ovr_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: framing, parity, glitch, break,
// FIFO overrun/simultaneous push-pop and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_ovs;

    localparam int OVS = 16;
    localparam int LAT = 155;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tick = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       stop2 = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_valid;
    logic       rx_done;
    logic       overrun;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int tick_div = 4;
    int tcnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_done_cyc = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int done_nv = 0;

    uart_rx_ovs #(.DATA_BITS(8), .OVS(OVS), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .tick       (tick),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .rx_data    (rx_data),
        .rx_perr    (rx_perr),
        .rx_ferr    (rx_ferr),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_done    (rx_done),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick = (tcnt == 0);
            tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt <= done_cnt + 1;
            last_done_cyc <= cyc;
            if (!rx_valid) done_nv <= done_nv + 1;
        end
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic send_frame(input logic [7:0] d, input logic pen,
                              input logic pbit, input logic s1,
                              input logic s2, input logic two,
                              input int rdy_at);
        logic [11:0] bits;
        int n;
        int len;
        bits = '1;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (pen) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = s1;
        n++;
        if (two) begin
            bits[n] = s2;
            n++;
        end
        len = OVS * tick_div;
        for (int k = 0; k < n * len; k++) begin
            if (k == 0) start_cyc = cyc;
            rx = bits[k / len];
            rx_ready = (k == rdy_at);
            @(negedge clk);
        end
        rx_ready = 1'b0;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h exp 00", rx_data);
        end
        checks++;
        if ({rx_perr, rx_ferr, rx_valid, rx_done, overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {rx_perr, rx_ferr, rx_valid, rx_done, overrun});
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", fifo_count);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_done got %0d exp 1", done_cnt - d0);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data got %h exp a5", rx_data);
        end
        checks++;
        if ({rx_perr, rx_ferr, rx_valid} !== 3'b001) begin
            errors++;
            $display("FAIL basic_flags got %b exp 001",
                     {rx_perr, rx_ferr, rx_valid});
        end
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL basic_count got %0d exp 1", fifo_count);
        end
        pop_one();
        checks++;
        if ({rx_valid, fifo_count} !== 4'b0000) begin
            errors++;
            $display("FAIL basic_pop got v=%b c=%0d exp v=0 c=0",
                     rx_valid, fifo_count);
        end
    endtask

    task automatic test_parity();
        logic pb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic od [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic ep [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        parity_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            parity_odd = od[i];
            send_frame(8'h03, 1'b1, pb[i], 1'b1, 1'b1, 1'b0, -1);
            checks++;
            if ({rx_data, rx_perr, rx_ferr} !== {8'h03, ep[i], 1'b0}) begin
                errors++;
                $display("FAIL parity_%0d got d=%h p=%b f=%b exp d=03 p=%b f=0",
                         i, rx_data, rx_perr, rx_ferr, ep[i]);
            end
            pop_one();
        end
        parity_en = 1'b0;
        parity_odd = 1'b0;
    endtask

    task automatic test_glitch();
        int d0;
        d0 = done_cnt;
        rx = 1'b0;
        repeat (4 * tick_div) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL glitch_done got %0d exp 0", done_cnt - d0);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL glitch_count got %0d exp 0", fifo_count);
        end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checks++;
        if ({rx_data, rx_ferr, fifo_count} !== {8'h5A, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL glitch_next got d=%h f=%b c=%0d exp d=5a f=0 c=1",
                     rx_data, rx_ferr, fifo_count);
        end
        pop_one();
    endtask

    task automatic test_break();
        int d0;
        d0 = done_cnt;
        stop2 = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        repeat (40 * tick_div) @(negedge clk);
        rx = 1'b1;
        repeat (OVS * tick_div) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL break_done got %0d exp 1", done_cnt - d0);
        end
        checks++;
        if ({rx_data, rx_perr, rx_ferr} !== {8'h3C, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL break_frame got d=%h p=%b f=%b exp d=3c p=0 f=1",
                     rx_data, rx_perr, rx_ferr);
        end
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL break_count got %0d exp 1", fifo_count);
        end
        pop_one();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        checks++;
        if ({rx_data, rx_ferr, fifo_count} !== {8'h11, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL break_next got d=%h f=%b c=%0d exp d=11 f=0 c=1",
                     rx_data, rx_ferr, fifo_count);
        end
        pop_one();
        stop2 = 1'b0;
    endtask

    task automatic test_overrun();
        int d0;
        int o0;
        d0 = done_cnt;
        o0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        end
        checks++;
        if (done_cnt - d0 !== 5 || ovr_cnt - o0 !== 1) begin
            errors++;
            $display("FAIL ovr_pulses got done=%0d ovr=%0d exp done=5 ovr=1",
                     done_cnt - d0, ovr_cnt - o0);
        end
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL ovr_count got %0d exp 4", fifo_count);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rx_data !== 8'(i)) begin
                errors++;
                $display("FAIL ovr_order_%0d got %h exp %h", i, rx_data, 8'(i));
            end
            pop_one();
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL ovr_drain got %0d exp 0", fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int o0;
        tick_div = 1;
        repeat (8) @(negedge clk);
        d0 = done_cnt;
        o0 = ovr_cnt;
        send_frame(8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checks++;
        if (last_done_cyc - start_cyc !== LAT) begin
            errors++;
            $display("FAIL b2b_latency got %0d exp %0d",
                     last_done_cyc - start_cyc, LAT);
        end
        for (int i = 7; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        end
        send_frame(8'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, LAT - 1);
        checks++;
        if (done_cnt - d0 !== 5 || ovr_cnt - o0 !== 0) begin
            errors++;
            $display("FAIL b2b_pulses got done=%0d ovr=%0d exp done=5 ovr=0",
                     done_cnt - d0, ovr_cnt - o0);
        end
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 4", fifo_count);
        end
        for (int i = 7; i <= 10; i++) begin
            checks++;
            if (rx_data !== 8'(i)) begin
                errors++;
                $display("FAIL b2b_order_%0d got %h exp %h", i, rx_data, 8'(i));
            end
            pop_one();
        end
        tick_div = 4;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int d0;
        logic [7:0] dd;
        int idx;
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        d0 = done_cnt;
        dd = 8'h55;
        for (int k = 0; k < 5 * OVS * tick_div + 32; k++) begin
            idx = k / (OVS * tick_div);
            rx = (idx == 0) ? 1'b0 : dd[idx-1];
            @(negedge clk);
        end
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({rx_data, rx_perr, rx_ferr, rx_valid, rx_done, overrun, fifo_count}
            !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_outputs got d=%h v=%b c=%0d exp all zero",
                     rx_data, rx_valid, fifo_count);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_after got done=%0d c=%0d exp done=0 c=0",
                     done_cnt - d0, fifo_count);
        end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        checks++;
        if ({rx_data, rx_perr, rx_ferr, fifo_count} !== {8'hC3, 2'b00, 3'd1}) begin
            errors++;
            $display("FAIL rst_mid_next got d=%h p=%b f=%b c=%0d exp d=c3 p=0 f=0 c=1",
                     rx_data, rx_perr, rx_ferr, fifo_count);
        end
        pop_one();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        checks++;
        if (done_nv !== 0) begin
            errors++;
            $display("FAIL done_without_valid got %0d exp 0", done_nv);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
- Parametrised UART receiver, successor to the fixed 8-bit, one-tick-per-bit receiver.
- Oversamples the serial line at OVS ticks per bit and centre-samples each bit.
- Adds runtime parity and stop-bit modes and per-frame error flags.
- Buffers received frames in a small show-ahead FIFO with a valid/ready pop handshake, feeding the APB-side register block.

Parameters:
- DATA_BITS, 8, data bits per frame; legal values 5 to 9.
- OVS, 16, tick pulses per bit time; even, at least 4.
- FIFO_DEPTH, 4, frame entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial line; idles high.
- tick  in  1  one-clk pulse at OVS x baud rate.
- parity_en  in  1  1 = a parity bit follows the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- stop2  in  1  1 = two stop bits.
- rx_data  out  DATA_BITS  data of the FIFO head entry.
- rx_perr  out  1  parity-error flag of the head entry.
- rx_ferr  out  1  framing-error flag of the head entry.
- rx_valid  out  1  FIFO is non-empty.
- rx_ready  in  1  consumer accepts the head entry.
- rx_done  out  1  one-clk pulse when a frame completes.
- overrun  out  1  one-clk pulse when a frame is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - FIFO empty; state IDLE; counters 0.
  - Both synchroniser flops 1.
- Input synchroniser: rx passes through a 2-flop synchroniser. All sampling uses the synchronised value rs.
- Counters and config: counters advance only on cycles where tick=1. parity_en, parity_odd and stop2 are latched on start detection; changes mid-frame have no effect.
- State machine:
  - IDLE: a falling edge of rs -> START. Clear tick counter and shift register.
  - START: after OVS/2 ticks, sample rs. If 1 -> IDLE (glitch rejected, no flags, no rx_done). If 0 -> DATA.
  - DATA: every OVS ticks, sample one bit, LSB first. After DATA_BITS samples -> PARITY if parity_en, otherwise STOP.
  - PARITY: sample after OVS ticks. perr = XOR(data bits, parity bit) XOR parity_odd. perr is 0 when parity_en=0.
  - STOP: sample after OVS ticks; a 0 sets ferr. If stop2=1, sample a second stop bit OVS ticks later; a 0 on either stop bit sets ferr.
  - After the last stop sample: attempt push of {data, perr, ferr} and pulse rx_done. Next state is IDLE if the last stop sample was 1, otherwise BREAK.
  - BREAK: wait until rs=1, then -> IDLE. This prevents a held-low line from being read as repeated frames.
- Frame completion timing: rx_done pulses in the clk cycle after the tick of the final stop sample. The entry is visible on rx_valid/rx_data in that same cycle.
- FIFO:
  - Show-ahead: rx_data, rx_perr and rx_ferr always reflect the head entry. Their value is don't-care when rx_valid=0.
  - Pop occurs when rx_valid && rx_ready.
  - Push when full with no pop in the same cycle: the new frame is dropped, overrun pulses, rx_done still pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted, no overrun, count unchanged.
  - Push and pop in the same cycle while count=1: the new entry becomes head, count stays 1.
  - Pop when empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH. fifo_count is the registered occupancy, from 0 to FIFO_DEPTH.
- Reset mid-frame: the partial frame is discarded, the FIFO is emptied, and no rx_done pulses.
- A tick pulse coincident with reset deassertion is ignored.

Test Plan:
- DATA_BITS=8, OVS=16, no parity, 1 stop: send 0xA5 -> rx_done pulses once. rx_data=0xA5, rx_perr=0, rx_ferr=0, fifo_count=1. Pop with rx_ready -> count 0, rx_valid=0.
- parity_en=1, parity_odd=0: send 0x03 with parity bit 1 -> rx_perr=1. Resend with parity bit 0 -> rx_perr=0. Then odd mode, 0x03 with parity bit 1 -> rx_perr=0.
- Low glitch on rx lasting 4 ticks while IDLE -> no rx_done, fifo_count stays 0, state returns to IDLE. A following valid 0x5A is received correctly.
- stop2=1: send 0x3C with first stop 1 and second stop 0 -> rx_ferr=1. Hold rx low for 40 ticks -> no extra frames. Raise rx, then send 0x11 -> received with ferr=0.
- FIFO_DEPTH=4, rx_ready=0: send 0x01 to 0x05 -> 5th frame gives rx_done plus overrun, count=4. Pop all -> order 0x01 to 0x04. Also hold rx_ready=1 at the 5th frame's completion while full -> no overrun.
- Assert rst_n=0 during bit 4 of a frame, then release -> all outputs 0, count=0. The next full frame 0xC3 is received intact.
